mul_iter: RTL

MUL_ITER -- requirements
Module: mul_iter

---
 rtl/mul_iter_pkg.sv | 26 ++
 rtl/mul_iter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative multiplier.
// Contents: FSM state encodings, ready-flag levels, operand/product widths,
// and a helper that turns a possibly-signed operand into its magnitude.
package mul_iter_pkg;

    localparam int OP_W     = 32;
    localparam int DOUBLE_W = 64;

    localparam logic MUL_RESULT_READY     = 1'b1;
    localparam logic MUL_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        MUL_FREE = 2'b00,
        MUL_ZERO = 2'b01,
        MUL_ON   = 2'b10,
        MUL_END  = 2'b11
    } mul_state_e;

    // Two's-complement magnitude; -2^31 maps to 0x8000_0000, which is still
    // representable as an unsigned 32-bit magnitude.
    function automatic logic [OP_W-1:0] op_magnitude(input logic [OP_W-1:0] op,
                                                     input logic            is_signed);
        return (is_signed && op[OP_W-1]) ? (~op + 1'b1) : op;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 -> 64 shift-and-add multiplier, signed or unsigned.
// Uses the same start/annul/ready handshake as the divider so EX-stage stall
// logic can be shared.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   signed_mul_i  1 = two's-complement operands (sampled with start_i)
//   opdata1_i     multiplicand (sampled with start_i)
//   opdata2_i     multiplier (sampled with start_i)
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       abort an in-flight operation
//   result_o      {hi, lo} product, zero unless ready_o is high
//   ready_o       product valid
//
// state    | meaning
// ---------+----------------------------------------------------------
// MUL_FREE | idle, waiting for start_i
// MUL_ZERO | an operand was zero; product forced to 0
// MUL_ON   | 32 shift-and-add iterations in progress
// MUL_END  | product presented while start_i stays high
module mul_iter
    import mul_iter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_mul_i,
    input  logic [OP_W-1:0]     opdata1_i,
    input  logic [OP_W-1:0]     opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [DOUBLE_W-1:0] result_o,
    output logic                ready_o
);

    mul_state_e      state;
    logic [OP_W-1:0] mcand;
    logic [OP_W-1:0] acc_hi;
    logic [OP_W-1:0] mplier;    // low product half shares this register
    logic [4:0]      cnt;
    logic            neg;

    logic [OP_W-1:0]     addend;
    logic [OP_W:0]       sum;
    logic [DOUBLE_W-1:0] step;
    logic [DOUBLE_W-1:0] final_prod;

    // One iteration: 33-bit add into the upper half, then shift
    // {carry, acc_hi, mplier} right by one.
    always_comb begin
        addend     = mplier[0] ? mcand : '0;
        sum        = {1'b0, acc_hi} + {1'b0, addend};
        step       = {sum, mplier[OP_W-1:1]};
        final_prod = neg ? (~step + 1'b1) : step;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MUL_FREE;
            mcand    <= '0;
            acc_hi   <= '0;
            mplier   <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            result_o <= '0;
            ready_o  <= MUL_RESULT_NOT_READY;
        end else begin
            case (state)
                MUL_FREE: begin
                    result_o <= '0;
                    ready_o  <= MUL_RESULT_NOT_READY;
                    if (start_i && !annul_i) begin
                        if (opdata1_i == '0 || opdata2_i == '0) begin
                            state <= MUL_ZERO;
                        end else begin
                            state  <= MUL_ON;
                            mcand  <= op_magnitude(opdata1_i, signed_mul_i);
                            mplier <= op_magnitude(opdata2_i, signed_mul_i);
                            acc_hi <= '0;
                            cnt    <= '0;
                            neg    <= signed_mul_i & (opdata1_i[OP_W-1] ^ opdata2_i[OP_W-1]);
                        end
                    end
                end
                MUL_ZERO: begin
                    if (annul_i) begin
                        state <= MUL_FREE;
                    end else begin
                        acc_hi <= '0;
                        mplier <= '0;
                        state  <= MUL_END;
                    end
                end
                MUL_ON: begin
                    if (annul_i) begin
                        state <= MUL_FREE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            {acc_hi, mplier} <= final_prod;
                            state            <= MUL_END;
                        end else begin
                            {acc_hi, mplier} <= step;
                        end
                    end
                end
                MUL_END: begin
                    // ready_o rises one edge after entering END so the
                    // non-zero path lands at N+33 and the zero path at N+2.
                    if (start_i) begin
                        result_o <= {acc_hi, mplier};
                        ready_o  <= MUL_RESULT_READY;
                    end else begin
                        state    <= MUL_FREE;
                        result_o <= '0;
                        ready_o  <= MUL_RESULT_NOT_READY;
                    end
                end
                default: state <= MUL_FREE;
            endcase
        end
    end

endmodule
